delay_sweep_ctrl: RTL and testbench

- Sequencer for the 15-tap variable delay line.
- Drives the delay-select input through a programmable sweep from start to end in fixed steps.
- Holds each setting for a programmable dwell and masks the settling window after every change.
- Sits beside the delay-line top; provides a start/busy/done handshake to test or calibration logic.

---
 rtl/delay_sweep_pkg.sv | 23 ++
 rtl/delay_sweep_step.sv | 39 +++
 rtl/delay_sweep_ctrl.sv | 147 ++++++++++++++
 tb/tb_delay_sweep_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/delay_sweep_pkg.sv
// Shared types and defaults for the delay-line sweep sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package delay_sweep_pkg;

    localparam int DELAY_W        = 4;
    localparam int SETTLE_CYC_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    // Counter must hold both the settle reload and the widest dwell reload.
    function automatic int sweep_cnt_w(input int dwell_w, input int settle_cyc);
        int settle_w;
        settle_w = $clog2(settle_cyc + 1);
        return (dwell_w > settle_w) ? dwell_w : settle_w;
    endfunction

endpackage

// File: rtl/delay_sweep_step.sv
// Next sweep point: current +/- step, clamped to the end point without wrap or underflow.
// Latency: combinational.
// Backpressure: none.
module delay_sweep_step
    import delay_sweep_pkg::*;
#(
    parameter int WIDTH = DELAY_W
) (
    input  logic [WIDTH-1:0] cur_dly,
    input  logic [WIDTH-1:0] end_dly,
    input  logic [WIDTH-1:0] step_dly,
    input  logic             dir_down,
    output logic [WIDTH-1:0] next_dly,
    output logic             at_end
);

    logic [WIDTH-1:0] step_eff;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;

    always_comb begin
        step_eff = (step_dly == '0) ? WIDTH'(1) : step_dly;
        sum_ext  = {1'b0, cur_dly} + {1'b0, step_eff};
        // MSB of the extended difference flags an underflow below zero.
        diff_ext = {1'b0, cur_dly} - {1'b0, step_eff};
        next_dly = end_dly;
        if (dir_down) begin
            if (!diff_ext[WIDTH] && (diff_ext[WIDTH-1:0] > end_dly)) begin
                next_dly = diff_ext[WIDTH-1:0];
            end
        end else begin
            if (sum_ext < {1'b0, end_dly}) begin
                next_dly = sum_ext[WIDTH-1:0];
            end
        end
        at_end = (cur_dly == end_dly);
    end

endmodule

// File: rtl/delay_sweep_ctrl.sv
// Delay-line sweep sequencer: start..end in steps, settle mask then dwell per point (loop mode under DELAY_SWEEP_LOOP_EN).
// Latency: select updates on the start edge; each point takes SETTLE_CYC + dwell cycles, plus one DONE cycle.
// Backpressure: none; start_i is ignored while busy or in DONE, stop_i aborts to DONE on the next edge.
module delay_sweep_ctrl
    import delay_sweep_pkg::*;
#(
    parameter int WIDTH      = DELAY_W,
    parameter int DWELL_W    = 8,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [WIDTH-1:0]   start_delay_i,
    input  logic [WIDTH-1:0]   end_delay_i,
    input  logic [WIDTH-1:0]   step_i,
    input  logic [DWELL_W-1:0] dwell_i,
`ifdef DELAY_SWEEP_LOOP_EN
    input  logic               loop_i,
`endif
    output logic [WIDTH-1:0]   data_delay_o,
    output logic               sample_valid_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int CNT_W = sweep_cnt_w(DWELL_W, SETTLE_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    sweep_state_t       state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   start_q;
    logic [WIDTH-1:0]   end_q;
    logic [WIDTH-1:0]   step_q;
    logic [DWELL_W-1:0] dwell_m1_q;
    logic               dir_down_q;
    logic               wrap_pass;
    logic [WIDTH-1:0]   next_dly;
    logic               at_end;

`ifdef DELAY_SWEEP_LOOP_EN
    logic loop_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            loop_q <= 1'b0;
        end else if (state_q == IDLE && start_i) begin
            loop_q <= loop_i;
        end
    end

    assign wrap_pass = loop_q;
`else
    assign wrap_pass = 1'b0;
`endif

    delay_sweep_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .cur_dly  (data_delay_o),
        .end_dly  (end_q),
        .step_dly (step_q),
        .dir_down (dir_down_q),
        .next_dly (next_dly),
        .at_end   (at_end)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            start_q        <= '0;
            end_q          <= '0;
            step_q         <= '0;
            dwell_m1_q     <= '0;
            dir_down_q     <= 1'b0;
            data_delay_o   <= '0;
            sample_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        start_q        <= start_delay_i;
                        end_q          <= end_delay_i;
                        step_q         <= (step_i == '0) ? WIDTH'(1) : step_i;
                        dwell_m1_q     <= (dwell_i == '0) ? '0 : dwell_i - DWELL_W'(1);
                        dir_down_q     <= (start_delay_i > end_delay_i);
                        data_delay_o   <= start_delay_i;
                        busy_o         <= 1'b1;
                        sample_valid_o <= 1'b0;
                        cnt_q          <= SETTLE_LAST;
                        state_q        <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (stop_i) begin
                        state_q        <= DONE;
                        busy_o         <= 1'b0;
                        sample_valid_o <= 1'b0;
                        done_o         <= 1'b1;
                        cnt_q          <= '0;
                    end else if (cnt_q == '0) begin
                        state_q        <= DWELL;
                        sample_valid_o <= 1'b1;
                        cnt_q          <= CNT_W'(dwell_m1_q);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DWELL: begin
                    if (stop_i) begin
                        state_q        <= DONE;
                        busy_o         <= 1'b0;
                        sample_valid_o <= 1'b0;
                        done_o         <= 1'b1;
                        cnt_q          <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (at_end && !wrap_pass) begin
                        state_q        <= DONE;
                        busy_o         <= 1'b0;
                        sample_valid_o <= 1'b0;
                        done_o         <= 1'b1;
                    end else begin
                        // A looping sweep restarts from the first point and flags the new pass.
                        data_delay_o   <= at_end ? start_q : next_dly;
                        done_o         <= at_end;
                        sample_valid_o <= 1'b0;
                        cnt_q          <= SETTLE_LAST;
                        state_q        <= SETTLE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Directed bench for delay_sweep_ctrl: hand-computed sweep point lists checked cycle by cycle.
module tb_delay_sweep_ctrl;

    localparam int SC = 3;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       start_i;
    logic       stop_i;
    logic [3:0] start_delay_i;
    logic [3:0] end_delay_i;
    logic [3:0] step_i;
    logic [7:0] dwell_i;
    logic [3:0] data_delay_o;
    logic       sample_valid_o;
    logic       busy_o;
    logic       done_o;
`ifdef DELAY_SWEEP_LOOP_EN
    logic       loop_i;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    delay_sweep_ctrl #(
        .WIDTH      (4),
        .DWELL_W    (8),
        .SETTLE_CYC (SC)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .start_delay_i  (start_delay_i),
        .end_delay_i    (end_delay_i),
        .step_i         (step_i),
        .dwell_i        (dwell_i),
`ifdef DELAY_SWEEP_LOOP_EN
        .loop_i         (loop_i),
`endif
        .data_delay_o   (data_delay_o),
        .sample_valid_o (sample_valid_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] dly, input logic vld,
                              input logic bsy, input logic dn);
        check({tag, "_dly"}, data_delay_o, dly);
        check({tag, "_vld"}, sample_valid_o, vld);
        check({tag, "_busy"}, busy_o, bsy);
        check({tag, "_done"}, done_o, dn);
    endtask

    // Returns at the first sampling point after the start edge; inputs are then scrambled.
    task automatic do_start(input logic [3:0] s, input logic [3:0] e, input logic [3:0] st,
                            input logic [7:0] dw);
        @(negedge clk_i);
        start_delay_i = s;
        end_delay_i   = e;
        step_i        = st;
        dwell_i       = dw;
        start_i       = 1'b1;
        @(negedge clk_i);
        start_i       = 1'b0;
        start_delay_i = ~s;
        end_delay_i   = ~e;
        step_i        = st + 4'd1;
        dwell_i       = dw + 8'd3;
    endtask

    // pts holds the expected points, first point in the low nibble.
    task automatic run_sweep(input string tag, input logic [3:0] s, input logic [3:0] e,
                             input logic [3:0] st, input logic [7:0] dw, input int dw_eff,
                             input int npts, input logic [15:0] pts, input int pulse_at);
        int         per;
        int         total;
        int         mism;
        int         busy_cnt;
        int         done_cnt;
        int         vld_cnt;
        logic [3:0] ep;
        logic       ev;
        logic       eb;
        logic       ed;
        per      = SC + dw_eff;
        total    = npts * per;
        mism     = 0;
        busy_cnt = 0;
        done_cnt = 0;
        vld_cnt  = 0;
        do_start(s, e, st, dw);
        for (int i = 0; i <= total + 1; i++) begin
            if (i < total) begin
                ep = pts[4*(i/per) +: 4];
                ev = (i % per) >= SC;
                eb = 1'b1;
                ed = 1'b0;
            end else begin
                ep = pts[4*(npts-1) +: 4];
                ev = 1'b0;
                eb = 1'b0;
                ed = (i == total);
            end
            if ({data_delay_o, sample_valid_o, busy_o, done_o} !== {ep, ev, eb, ed}) mism++;
            busy_cnt += int'(busy_o);
            done_cnt += int'(done_o);
            vld_cnt  += int'(sample_valid_o);
            start_i = (i == pulse_at);
            @(negedge clk_i);
        end
        start_i = 1'b0;
        check({tag, "_trace_mismatch_cycles"}, mism, 0);
        check({tag, "_busy_cycles"}, busy_cnt, total);
        check({tag, "_valid_cycles"}, vld_cnt, npts * dw_eff);
        check({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        rst_n_i       = 1'b0;
        start_i       = 1'b0;
        stop_i        = 1'b0;
        start_delay_i = '0;
        end_delay_i   = '0;
        step_i        = '0;
        dwell_i       = '0;
`ifdef DELAY_SWEEP_LOOP_EN
        loop_i        = 1'b0;
`endif
        repeat (2) @(negedge clk_i);
        check_outs("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check_outs("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0);

        // Up sweep 2,5,8; down sweep 10,6,3 with a clamped last step.
        run_sweep("up_2_8_s3", 4'd2, 4'd8, 4'd3, 8'd4, 4, 3, 16'h0852, -1);
        run_sweep("down_10_3_s4", 4'd10, 4'd3, 4'd4, 8'd2, 2, 3, 16'h036A, -1);
        // 13+5 would wrap to 2 in four bits; a start pulse mid-sweep is ignored.
        run_sweep("up_clamp_13_15", 4'd13, 4'd15, 4'd5, 8'd1, 1, 2, 16'h00FD, 2);
        // 5-7 would underflow; must clamp to 1.
        run_sweep("down_clamp_5_1", 4'd5, 4'd1, 4'd7, 8'd1, 1, 2, 16'h0015, -1);
        run_sweep("single_point_7", 4'd7, 4'd7, 4'd2, 8'd3, 3, 1, 16'h0007, -1);
        run_sweep("zero_step_dwell", 4'd0, 4'd2, 4'd0, 8'd0, 1, 3, 16'h0210, -1);

        // Abort during the dwell on value 4 (points are 5 cycles long with dwell 2).
        do_start(4'd0, 4'd15, 4'd1, 8'd2);
        repeat (23) @(negedge clk_i);
        check_outs("pre_stop", 4'd4, 1'b1, 1'b1, 1'b0);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        check_outs("stop_done", 4'd4, 1'b0, 1'b0, 1'b1);
        start_delay_i = 4'd9;
        start_i       = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check_outs("start_in_done_ignored", 4'd4, 1'b0, 1'b0, 1'b0);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        check_outs("stop_in_idle", 4'd4, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of SETTLE, between clock edges.
        do_start(4'd5, 4'd9, 4'd2, 8'd2);
        @(negedge clk_i);
        check_outs("pre_reset_settle", 4'd5, 1'b0, 1'b1, 1'b0);
        #2 rst_n_i = 1'b0;
        #1 check_outs("async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
        #1 rst_n_i = 1'b1;
        run_sweep("after_reset_1_3", 4'd1, 4'd3, 4'd2, 8'd1, 1, 2, 16'h0031, -1);

`ifdef DELAY_SWEEP_LOOP_EN
        // Loop mode: 0,1 repeated; done_o marks the first cycle of each new pass.
        loop_i = 1'b1;
        do_start(4'd0, 4'd1, 4'd1, 8'd0);
        loop_i = 1'b0;
        repeat (8) @(negedge clk_i);
        check_outs("loop_pass2", 4'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk_i);
        check_outs("loop_pass2_next", 4'd0, 1'b0, 1'b1, 1'b0);
        repeat (7) @(negedge clk_i);
        check_outs("loop_pass3", 4'd0, 1'b0, 1'b1, 1'b1);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        check_outs("loop_stop", 4'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk_i);
        check_outs("loop_idle", 4'd0, 1'b0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
